// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester/response and shared-ALU signal bundle for alu_arbiter
interface alu_arbiter_if;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_port_A, req0_port_B, req1_port_A, req1_port_B;
  logic [3:0]  req0_alu_op, req1_alu_op;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_outport;
  logic [2:0]  rsp_flags;
  logic [31:0] alu_port_A, alu_port_B;
  logic [3:0]  alu_op;
  logic [31:0] alu_outport;
  logic        alu_zero, alu_neg, alu_overflow;

  modport master (
    output req0_valid, req1_valid, req0_port_A, req0_port_B, req1_port_A, req1_port_B,
           req0_alu_op, req1_alu_op, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_outport, rsp_flags
  );

  modport slave (
    input  req0_valid, req1_valid, req0_port_A, req0_port_B, req1_port_A, req1_port_B,
           req0_alu_op, req1_alu_op, rsp0_ready, rsp1_ready,
           alu_outport, alu_zero, alu_neg, alu_overflow,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_outport, rsp_flags,
           alu_port_A, alu_port_B, alu_op
  );

  modport alu (
    input  alu_port_A, alu_port_B, alu_op,
    output alu_outport, alu_zero, alu_neg, alu_overflow
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
module alu_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        prio_q, prio_d;
  logic        grant_q, grant_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [3:0]  op_code_q, op_code_d;
  logic [31:0] rsp_out_q, rsp_out_d;
  logic [2:0]  rsp_flags_q, rsp_flags_d;
  logic        take0, take1, rsp_done;

  // Ready is gated by rst so nothing is accepted while reset is held.
  always_comb begin
    take0    = !rst && (state_q == S_IDLE) && bus.req0_valid && (!bus.req1_valid || !prio_q);
    take1    = !rst && (state_q == S_IDLE) && bus.req1_valid && (!bus.req0_valid || prio_q);
    rsp_done = (state_q == S_RESP) && (grant_q ? bus.rsp1_ready : bus.rsp0_ready);
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    grant_d     = grant_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_code_d   = op_code_q;
    rsp_out_d   = rsp_out_q;
    rsp_flags_d = rsp_flags_q;
    case (state_q)
      S_IDLE: begin
        if (take0) begin
          op_a_d    = bus.req0_port_A;
          op_b_d    = bus.req0_port_B;
          op_code_d = bus.req0_alu_op;
          grant_d   = 1'b0;
          state_d   = S_EXEC;
        end else if (take1) begin
          op_a_d    = bus.req1_port_A;
          op_b_d    = bus.req1_port_B;
          op_code_d = bus.req1_alu_op;
          grant_d   = 1'b1;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_out_d   = bus.alu_outport;
        rsp_flags_d = {bus.alu_overflow, bus.alu_neg, bus.alu_zero};
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_done) begin
          prio_d  = ~grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      prio_q      <= RR_INIT;
      grant_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_code_q   <= '0;
      rsp_out_q   <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      grant_q     <= grant_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_code_q   <= op_code_d;
      rsp_out_q   <= rsp_out_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign bus.req0_ready  = take0;
  assign bus.req1_ready  = take1;
  assign bus.rsp0_valid  = (state_q == S_RESP) && !grant_q;
  assign bus.rsp1_valid  = (state_q == S_RESP) && grant_q;
  assign bus.rsp_outport = rsp_out_q;
  assign bus.rsp_flags   = rsp_flags_q;
  assign bus.alu_port_A  = op_a_q;
  assign bus.alu_port_B  = op_b_q;
  assign bus.alu_op      = op_code_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU and reference model
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_arbiter_if bus ();

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, others pass A. Returns {ovf, neg, zero, result}.
  function automatic logic [34:0] alu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        ov;
    ov = 1'b0;
    case (op)
      4'd0: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      default: r = a;
    endcase
    return {ov, r[31], (r == 32'd0), r};
  endfunction

  always_comb begin
    logic [34:0] res;
    res              = alu_calc(bus.alu_op, bus.alu_port_A, bus.alu_port_B);
    bus.alu_outport  = res[31:0];
    bus.alu_zero     = res[32];
    bus.alu_neg      = res[33];
    bus.alu_overflow = res[34];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rdy(input string name, input logic [1:0] exp);
    check({name, ".ready"}, {62'd0, bus.req1_ready, bus.req0_ready}, {62'd0, exp});
  endtask

  task automatic chk_rsp(input string name, input logic [1:0] exp);
    check({name, ".rsp_valid"}, {62'd0, bus.rsp1_valid, bus.rsp0_valid}, {62'd0, exp});
  endtask

  task automatic chk_result(input string name, input logic [31:0] out, input logic [2:0] flags);
    check({name, ".outport"}, {32'd0, bus.rsp_outport}, {32'd0, out});
    check({name, ".flags"}, {61'd0, bus.rsp_flags}, {61'd0, flags});
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
  endtask

  task automatic drive(input bit which, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (which) begin
      bus.req1_valid = 1; bus.req1_alu_op = op; bus.req1_port_A = a; bus.req1_port_B = b;
    end else begin
      bus.req0_valid = 1; bus.req0_alu_op = op; bus.req0_port_A = a; bus.req0_port_B = b;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1;
    #1;
    step();
    rst = 0;
  endtask

  // One uncontended operation, scrambling all request inputs while it executes.
  task automatic do_op(input string tag, input bit which, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_out, input logic [2:0] exp_flags);
    logic [1:0] sel;
    sel = which ? 2'b10 : 2'b01;
    @(negedge clk);
    drive(which, op, a, b);
    #1;
    chk_rdy(tag, sel);
    @(negedge clk);
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_port_A = ~a; bus.req1_port_A = ~a;
    bus.req0_port_B = ~b; bus.req1_port_B = ~b;
    bus.req0_alu_op = ~op; bus.req1_alu_op = ~op;
    #1;
    chk_rsp({tag, ".exec"}, 2'b00);
    check({tag, ".hold_A"}, {32'd0, bus.alu_port_A}, {32'd0, a});
    step();
    chk_rsp({tag, ".resp"}, sel);
    chk_result(tag, exp_out, exp_flags);
    if (which) bus.rsp1_ready = 1; else bus.rsp0_ready = 1;
    step();
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    chk_rsp({tag, ".done"}, 2'b00);
  endtask

  typedef struct {
    bit          which;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic [2:0]  exp_flags;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic        m_busy, m_owner, m_prio, v0, v1, win;
    int          m_age, n_done;
    logic [34:0] m_exp;
    logic [1:0]  exp_rdy;

    vecs[0] = '{0, 4'd0, 32'd5,         32'd7,         32'd12,        3'b000};
    vecs[1] = '{0, 4'd1, 32'd3,         32'd3,         32'd0,         3'b001};
    vecs[2] = '{1, 4'd0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 3'b110};
    vecs[3] = '{1, 4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 3'b000};
    vecs[4] = '{0, 4'd1, 32'd0,         32'd1,         32'hFFFF_FFFF, 3'b010};
    vecs[5] = '{1, 4'd4, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'd0,         3'b001};
    vecs[6] = '{0, 4'd1, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 3'b100};
    vecs[7] = '{1, 4'd3, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 3'b000};

    // Reset held with both requesters asking.
    clear_inputs();
    drive(0, 4'd0, 32'd1, 32'd2);
    drive(1, 4'd1, 32'd10, 32'd4);
    step(); step();
    chk_rdy("reset", 2'b00);
    chk_rsp("reset", 2'b00);
    chk_result("reset", 32'd0, 3'b000);
    check("reset.alu_A", {32'd0, bus.alu_port_A}, 64'd0);
    check("reset.alu_op", {60'd0, bus.alu_op}, 64'd0);

    // Contention: req0, req1, then req0 again.
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    @(negedge clk); rst = 0; #1;
    chk_rdy("cont.r0", 2'b01);
    step(); chk_rdy("cont.exec0", 2'b00); chk_rsp("cont.exec0", 2'b00);
    step(); chk_rsp("cont.resp0", 2'b01); chk_result("cont.resp0", 32'd3, 3'b000);
    step(); chk_rdy("cont.r1", 2'b10);
    step(); chk_rsp("cont.exec1", 2'b00);
    step(); chk_rsp("cont.resp1", 2'b10); chk_result("cont.resp1", 32'd6, 3'b000);
    step(); chk_rdy("cont.r0b", 2'b01);
    @(negedge clk); bus.req0_valid = 0; bus.req1_valid = 0; #1;
    step(); chk_rsp("cont.resp0b", 2'b01);
    step(); clear_inputs(); chk_rsp("cont.idle", 2'b00);

    for (int i = 0; i < 8; i++)
      do_op($sformatf("vec%0d", i), vecs[i].which, vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].exp_out, vecs[i].exp_flags);

    // Backpressure on req1 while req0 waits and rsp0_ready is asserted.
    @(negedge clk); drive(1, 4'd0, 32'd100, 32'd23); #1;
    chk_rdy("bp.r1", 2'b10);
    @(negedge clk);
    bus.req1_valid = 0; bus.rsp0_ready = 1;
    drive(0, 4'd1, 32'd50, 32'd8);
    #1;
    chk_rdy("bp.exec", 2'b00);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_rsp($sformatf("bp.hold%0d", k), 2'b10);
      chk_rdy($sformatf("bp.hold%0d", k), 2'b00);
      chk_result($sformatf("bp.hold%0d", k), 32'd123, 3'b000);
    end
    step(); bus.rsp1_ready = 1;
    chk_rsp("bp.release", 2'b10);
    step(); bus.rsp1_ready = 0;
    chk_rsp("bp.after", 2'b00); chk_rdy("bp.r0", 2'b01);
    @(negedge clk); bus.req0_valid = 0; #1;
    step(); chk_rsp("bp.resp0", 2'b01); chk_result("bp.resp0", 32'd42, 3'b000);
    step(); clear_inputs();

    // Reset during EXEC aborts the operation.
    @(negedge clk); drive(0, 4'd0, 32'd9, 32'd9); #1;
    chk_rdy("rmid.acc", 2'b01);
    @(negedge clk); bus.req0_valid = 0; #1;
    rst = 1; #1;
    chk_rsp("rmid.async", 2'b00); chk_rdy("rmid.async", 2'b00);
    chk_result("rmid.async", 32'd0, 3'b000);
    check("rmid.alu_A", {32'd0, bus.alu_port_A}, 64'd0);
    check("rmid.alu_op", {60'd0, bus.alu_op}, 64'd0);
    step();
    @(negedge clk); rst = 0; #1;
    for (int k = 0; k < 3; k++) begin
      chk_rsp($sformatf("rmid.quiet%0d", k), 2'b00);
      step();
    end
    do_op("rmid.next", 1, 4'd0, 32'd20, 32'd22, 32'd42, 3'b000);

    // Randomised traffic against an operation-level reference model.
    pulse_reset();
    m_busy = 0; m_owner = 0; m_prio = 0; m_age = 0; n_done = 0; m_exp = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      bus.req0_valid = v0; bus.req1_valid = v1;
      bus.req0_alu_op = 4'($urandom_range(0, 5)); bus.req1_alu_op = 4'($urandom_range(0, 5));
      bus.req0_port_A = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      bus.req0_port_B = $urandom_range(0, 1) ? bus.req0_port_A : $urandom;
      bus.req1_port_A = $urandom;
      bus.req1_port_B = $urandom_range(0, 1) ? 32'd1 : $urandom;
      bus.rsp0_ready = 1'($urandom_range(0, 1));
      bus.rsp1_ready = 1'($urandom_range(0, 1));
      #1;
      win = (v0 && v1) ? m_prio : v1;
      exp_rdy = (m_busy || !(v0 || v1)) ? 2'b00 : (win ? 2'b10 : 2'b01);
      chk_rdy($sformatf("rnd%0d", cyc), exp_rdy);
      chk_rsp($sformatf("rnd%0d", cyc), (m_busy && m_age >= 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
      if (m_busy && m_age >= 2)
        chk_result($sformatf("rnd%0d", cyc), m_exp[31:0], m_exp[34:32]);
      if (!m_busy) begin
        if (v0 || v1) begin
          m_busy = 1; m_owner = win; m_age = 1;
          m_exp = win ? alu_calc(bus.req1_alu_op, bus.req1_port_A, bus.req1_port_B)
                      : alu_calc(bus.req0_alu_op, bus.req0_port_A, bus.req0_port_B);
        end
      end else if (m_age >= 2 && (m_owner ? bus.rsp1_ready : bus.rsp0_ready)) begin
        m_busy = 0; m_prio = ~m_owner; n_done++;
      end else begin
        m_age = 2;
      end
    end
    check("rnd.completions", {63'd0, (n_done >= 20)}, 64'd1);
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
